// File: rtl/gray_bin_pipe.sv
// gray_bin_pipe: pipelined Gray<->binary converter, direction chosen per word by in_mode.
// Latency: STAGES cycles in both modes; one word per cycle while out_ready=1.
// Backpressure: full stages hold under out_ready=0, ready ripples back combinationally; up to STAGES words buffered.
// Optional: define GRAY_STEP_CHECK_EN to flag Gray words that differ from the previous Gray word in more than one bit.
module gray_bin_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_mode,
  output logic [WIDTH-1:0] out_data,
  output logic             out_step_err
);

  // Number of prefix-chain bits each stage resolves, MSB first.
  localparam int CHUNK = (WIDTH + STAGES - 1) / STAGES;

  logic              rdy_q;
  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] mode_q;
  logic [WIDTH-1:0]  dat_q [STAGES];
  logic [WIDTH-1:0]  nxt   [STAGES];
  logic [STAGES:0]   load;
  logic              in_fire;

  // Resolve the prefix-XOR bits belonging to stage k. Bits above this stage's
  // chunk are already binary; bits below it are still raw Gray.
  function automatic logic [WIDTH-1:0] resolve(input logic [WIDTH-1:0] w, input int k);
    logic [WIDTH-1:0] r;
    r = w;
    for (int i = WIDTH - 2; i >= 0; i--) begin
      if ((WIDTH - 1 - i) >= k * CHUNK && (WIDTH - 1 - i) < (k + 1) * CHUNK) begin
        r[i] = r[i+1] ^ r[i];
      end
    end
    return r;
  endfunction

  // Load enables ripple back from the output: a stage may take new data when
  // it is empty or when its contents move on in the same cycle.
  always_comb begin
    load         = '0;
    load[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      load[k] = !v_q[k] || load[k+1];
    end
  end

  assign in_ready = rdy_q & load[0];
  assign in_fire  = in_valid & in_ready;

  // Per-stage next data: binary->Gray finishes in stage 0 and rides through unchanged.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      nxt[k] = '0;
    end
    nxt[0] = in_mode ? (in_data ^ (in_data >> 1)) : resolve(in_data, 0);
    for (int k = 1; k < STAGES; k++) begin
      nxt[k] = mode_q[k-1] ? dat_q[k-1] : resolve(dat_q[k-1], k);
    end
  end

  // Pipeline registers; data only moves when a valid word is loaded, so
  // outputs never change while a word is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q  <= 1'b0;
      v_q    <= '0;
      mode_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        dat_q[k] <= '0;
      end
    end else begin
      rdy_q <= 1'b1;
      if (load[0]) begin
        v_q[0] <= in_fire;
      end
      if (load[0] && in_fire) begin
        dat_q[0]  <= nxt[0];
        mode_q[0] <= in_mode;
      end
      for (int k = 1; k < STAGES; k++) begin
        if (load[k]) begin
          v_q[k] <= v_q[k-1];
        end
        if (load[k] && v_q[k-1]) begin
          dat_q[k]  <= nxt[k];
          mode_q[k] <= mode_q[k-1];
        end
      end
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign out_data  = dat_q[STAGES-1];
  assign out_mode  = mode_q[STAGES-1];

`ifdef GRAY_STEP_CHECK_EN
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0]  hist_q;
  logic              hist_vld_q;
  logic [STAGES-1:0] err_q;
  logic [WIDTH-1:0]  diff;
  logic              step_flag;

  // More than one differing bit means clearing the lowest set bit leaves something.
  always_comb begin
    diff      = in_data ^ hist_q;
    step_flag = !in_mode && hist_vld_q && ((diff & (diff - ONE)) != '0);
  end

  // History of the last accepted Gray word; a binary word breaks the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q     <= '0;
      hist_vld_q <= 1'b0;
    end else if (in_fire) begin
      if (in_mode) begin
        hist_vld_q <= 1'b0;
      end else begin
        hist_q     <= in_data;
        hist_vld_q <= 1'b1;
      end
    end
  end

  // Step flag travels alongside its word with the same load enables.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= '0;
    end else begin
      if (load[0] && in_fire) begin
        err_q[0] <= step_flag;
      end
      for (int k = 1; k < STAGES; k++) begin
        if (load[k] && v_q[k-1]) begin
          err_q[k] <= err_q[k-1];
        end
      end
    end
  end

  assign out_step_err = err_q[STAGES-1];
`else
  assign out_step_err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_bin_pipe.sv
// Bench for gray_bin_pipe: directed vector tables, hand sequences for stall and
// reset corners, a STAGES=3 full-rate sweep, and randomized traffic against a scoreboard.
module tb_gray_bin_pipe;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, in_mode, out_valid, out_ready, out_mode, out_step_err;
  logic [W-1:0] in_data, out_data;
  logic         i3_valid, i3_ready, i3_mode, o3_valid, o3_ready, o3_mode, o3_err;
  logic [W-1:0] i3_data, o3_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gray_bin_pipe #(.WIDTH(W), .STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_mode(out_mode), .out_data(out_data),
    .out_step_err(out_step_err)
  );

  gray_bin_pipe #(.WIDTH(W), .STAGES(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(i3_valid), .in_ready(i3_ready), .in_mode(i3_mode), .in_data(i3_data),
    .out_valid(o3_valid), .out_ready(o3_ready), .out_mode(o3_mode), .out_data(o3_data),
    .out_step_err(o3_err)
  );

  typedef struct {
    logic         mode;
    logic [W-1:0] din;
    logic [W-1:0] dout;
    logic         err;
  } vec_t;

  typedef struct {
    logic         mode;
    logic [W-1:0] d;
    logic         err;
  } exp_t;

  vec_t dir_tbl [8];
  vec_t str_tbl [10];
  exp_t sb_q [$];

  // Reference: binary is the XOR of all right shifts of the Gray word.
  function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
    logic [W-1:0] b;
    b = '0;
    for (int s = 0; s < W; s++) b = b ^ (g >> s);
    return b;
  endfunction

  function automatic logic [W-1:0] b2g(input logic [W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor, sampled mid-cycle where everything is settled.
  logic         h_vld = 1'b0;
  logic [W-1:0] h     = '0;
  logic         stalled = 1'b0;
  logic [W+1:0] stall_val = '0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sb_q.delete();
      h_vld   = 1'b0;
      stalled = 1'b0;
    end else begin
      if (stalled) chk("stall_stable", {out_valid, out_mode, out_step_err, out_data}, {1'b1, stall_val});
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_extra: got word %h expected none", out_data);
        end else begin
          e = sb_q.pop_front();
          chk("sb_out", {out_mode, out_step_err, out_data}, {e.mode, e.err, e.d});
        end
      end
      stalled   = out_valid && !out_ready;
      stall_val = {out_mode, out_step_err, out_data};
      if (in_valid && in_ready) begin
        e.mode = in_mode;
        e.d    = in_mode ? b2g(in_data) : g2b(in_data);
        e.err  = 1'b0;
`ifdef GRAY_STEP_CHECK_EN
        if (in_mode) begin
          h_vld = 1'b0;
        end else begin
          e.err = h_vld && ($countones(in_data ^ h) > 1);
          h     = in_data;
          h_vld = 1'b1;
        end
`endif
        sb_q.push_back(e);
      end
    end
  end

  // Send a table of words at full rate and compare outputs in order.
  task automatic run_stream(input int n);
    int  idx = 0;
    int  oc = 0;
    logic acc;
    out_ready = 1'b1;
    for (int c = 0; c < n + 6; c++) begin
      in_valid = (idx < n);
      if (idx < n) begin
        in_mode = str_tbl[idx].mode;
        in_data = str_tbl[idx].din;
        chk("stream_rdy", in_ready, 1);
      end
      acc = in_valid && in_ready;
      step();
      if (acc) idx++;
      if (out_valid) begin
        if (oc < n) begin
`ifdef GRAY_STEP_CHECK_EN
          chk("stream_out", {out_mode, out_step_err, out_data},
              {str_tbl[oc].mode, str_tbl[oc].err, str_tbl[oc].dout});
`else
          chk("stream_out", {out_mode, out_step_err, out_data},
              {str_tbl[oc].mode, 1'b0, str_tbl[oc].dout});
`endif
        end
        oc++;
      end
    end
    in_valid = 1'b0;
    chk("stream_count", oc, n);
  endtask

  initial begin
    int   idx, oc, first;
    logic acc;

    dir_tbl[0] = '{1'b0, 8'hC5, 8'h86, 1'b0};
    dir_tbl[1] = '{1'b1, 8'h86, 8'hC5, 1'b0};
    dir_tbl[2] = '{1'b0, 8'hFF, 8'hAA, 1'b0};
    dir_tbl[3] = '{1'b1, 8'hFF, 8'h80, 1'b0};
    dir_tbl[4] = '{1'b0, 8'h80, 8'hFF, 1'b0};
    dir_tbl[5] = '{1'b1, 8'hAA, 8'hFF, 1'b0};
    dir_tbl[6] = '{1'b0, 8'h01, 8'h01, 1'b0};
    dir_tbl[7] = '{1'b1, 8'h00, 8'h00, 1'b0};

    str_tbl[0] = '{1'b1, 8'h00, 8'h00, 1'b0};
    str_tbl[1] = '{1'b0, 8'hC5, 8'h86, 1'b0};
    str_tbl[2] = '{1'b0, 8'hC4, 8'h87, 1'b0};
    str_tbl[3] = '{1'b0, 8'hC7, 8'h85, 1'b1};
    str_tbl[4] = '{1'b1, 8'h10, 8'h18, 1'b0};
    str_tbl[5] = '{1'b0, 8'h00, 8'h00, 1'b0};
    str_tbl[6] = '{1'b0, 8'h3C, 8'h28, 1'b1};
    str_tbl[7] = '{1'b1, 8'h3C, 8'h22, 1'b0};
    str_tbl[8] = '{1'b0, 8'hF0, 8'hA0, 1'b0};
    str_tbl[9] = '{1'b1, 8'hF0, 8'h88, 1'b0};

    rst_n = 1'b0;
    in_valid = 1'b0; in_mode = 1'b0; in_data = '0; out_ready = 1'b1;
    i3_valid = 1'b0; i3_mode = 1'b0; i3_data = '0; o3_ready = 1'b1;

    // Reset state
    repeat (3) step();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_mode", out_mode, 0);
    chk("rst_step_err", out_step_err, 0);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready_low", in_ready, 0);
    step();
    chk("rel_in_ready_high", in_ready, 1);

    // Directed vectors, one word at a time, exact latency of 2
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_mode  = dir_tbl[i].mode;
      in_data  = dir_tbl[i].din;
      chk("dir_rdy", in_ready, 1);
      step();
      in_valid = 1'b0;
      chk("dir_lat1_valid", out_valid, 0);
      step();
      chk("dir_lat2_valid", out_valid, 1);
      chk("dir_out", {out_mode, out_data}, {dir_tbl[i].mode, dir_tbl[i].dout});
      step();
    end

    // Backpressure: two words fill the pipe, third waits
    out_ready = 1'b0;
    in_valid = 1'b1; in_mode = 1'b0; in_data = 8'h12;
    chk("stall_rdy0", in_ready, 1);
    step();
    in_mode = 1'b1; in_data = 8'h34;
    chk("stall_rdy1", in_ready, 1);
    step();
    in_mode = 1'b0; in_data = 8'h56;
    for (int i = 0; i < 3; i++) begin
      chk("stall_full_rdy", in_ready, 0);
      chk("stall_hold", {out_valid, out_mode, out_data}, {1'b1, 1'b0, 8'h1C});
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("stall_release_rdy", in_ready, 1);
    step();
    in_valid = 1'b0;
    chk("stall_w1", {out_valid, out_mode, out_data}, {1'b1, 1'b1, 8'h2E});
    step();
    chk("stall_w2", {out_valid, out_mode, out_data}, {1'b1, 1'b0, 8'h64});
    step();
    chk("stall_empty", out_valid, 0);

    // Reset with two words in flight
    in_valid = 1'b1; in_mode = 1'b0; in_data = 8'h12;
    step();
    in_data = 8'h34;
    step();
    in_valid = 1'b0;
    chk("mid_full", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_rdy", in_ready, 0);
    step();
    step();
    rst_n = 1'b1;
    #1;
    chk("mid_rel_rdy_low", in_ready, 0);
    step();
    chk("mid_rel_rdy_high", in_ready, 1);
    chk("mid_no_old", out_valid, 0);
    in_valid = 1'b1; in_mode = 1'b0; in_data = 8'hC5;
    step();
    in_valid = 1'b0;
    chk("mid_no_old2", out_valid, 0);
    step();
    chk("mid_new_word", {out_valid, out_mode, out_data}, {1'b1, 1'b0, 8'h86});
    step();
    chk("mid_after", out_valid, 0);

    // Full-rate stream with step-check and mode interleave
    run_stream(10);

    // STAGES=3: all 256 Gray codes back-to-back
    idx = 0; oc = 0; first = -1;
    for (int c = 0; c < 262; c++) begin
      i3_valid = (idx < 256);
      i3_mode  = 1'b0;
      i3_data  = b2g(idx[W-1:0]);
      if (idx < 256) chk("g3_rdy", i3_ready, 1);
      acc = i3_valid && i3_ready;
      step();
      if (acc) idx++;
      if (o3_valid) begin
        if (first < 0) first = c;
        chk("g3_data", o3_data, oc);
        chk("g3_rate", c - first, oc);
        oc++;
      end
    end
    i3_valid = 1'b0;
    chk("g3_count", oc, 256);

    // Randomized traffic against the scoreboard
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_mode   = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 1) in_data = in_data ^ (8'h01 << $urandom_range(0, 7));
      else                           in_data = 8'($urandom);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (8) step();
    chk("rand_drain", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
